// File: rtl/accumulate_sequencer.sv
// Switch accumulator: adds a zero-extended switch value into a running sum,
// one SLICE-bit slice per clock with a registered carry, once per button press.
module accumulate_sequencer #(
  parameter int WIDTH    = 17,
  parameter int IN_WIDTH = 10,
  parameter int SLICE    = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Clear,
  input  logic                Run_Accumulate,
  input  logic [IN_WIDTH-1:0] SW,
  output logic [WIDTH-1:0]    Sum,
  output logic                Busy,
  output logic                Done,
  output logic                Overflow,
  output logic [1:0]          state_dbg
);

  localparam int NSLICE   = (WIDTH + SLICE - 1) / SLICE;
  localparam int LAST_W   = WIDTH - SLICE * (NSLICE - 1);
  localparam int EW       = SLICE * NSLICE;
  localparam int IW       = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SHW      = $clog2(EW) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  // Handshake: Run_Accumulate is a level; a start is its 0->1 transition as
  // seen against run_q. HOLD waits for release, so a held button adds once.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    WB   = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] operand;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             run_q;
  logic             start;

  logic [SHW-1:0]   shamt;
  logic [EW-1:0]    w_ext;
  logic [EW-1:0]    o_ext;
  logic [EW-1:0]    slice_mask;
  logic [EW-1:0]    merged;
  logic [SLICE-1:0] w_slice;
  logic [SLICE-1:0] o_slice;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] work_next;
  logic             carry_next;

  assign start = Run_Accumulate & ~run_q;

  // Slice adder: bits above WIDTH are zero in both operands, so the narrow
  // last slice reuses the same adder and takes its carry from bit LAST_W.
  always_comb begin
    shamt      = SHW'(idx) * SHW'(SLICE);
    w_ext      = EW'(work);
    o_ext      = EW'(operand);
    slice_mask = EW'({SLICE{1'b1}}) << shamt;
    w_slice    = SLICE'(w_ext >> shamt);
    o_slice    = SLICE'(o_ext >> shamt);
    slice_sum  = (SLICE+1)'(w_slice) + (SLICE+1)'(o_slice) + (SLICE+1)'(carry);
    merged     = (w_ext & ~slice_mask) |
                 ((EW'(slice_sum[SLICE-1:0]) << shamt) & slice_mask);
    work_next  = WIDTH'(merged);
    carry_next = (idx == LAST_IDX) ? slice_sum[LAST_W] : slice_sum[SLICE];
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!Clear && start) state_next = ADD;
      ADD: begin
        if (Clear)                 state_next = IDLE;
        else if (idx == LAST_IDX)  state_next = WB;
      end
      WB:   state_next = Clear ? IDLE : HOLD;
      HOLD: if (!Run_Accumulate) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state == ADD) || (state == WB);
    state_dbg = state;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Sum      <= '0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
      work     <= '0;
      operand  <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      run_q    <= 1'b0;
    end else begin
      run_q <= Run_Accumulate;
      Done  <= 1'b0;
      if (Clear) begin
        Sum      <= '0;
        Overflow <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!Clear && start) begin
            operand <= WIDTH'(SW);
            work    <= Sum;
            carry   <= 1'b0;
            idx     <= '0;
          end
        end
        ADD: begin
          if (!Clear) begin
            work  <= work_next;
            carry <= carry_next;
            idx   <= idx + 1'b1;
          end
        end
        WB: begin
          if (!Clear) begin
            Sum      <= work;
            Overflow <= Overflow | carry;
            Done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulate_sequencer.sv
// Directed bench for accumulate_sequencer: stimulus pushes expected
// {Overflow, Sum} into a queue, a monitor pops and compares on each Done.
module tb_accumulate_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Clear;
  logic        Run_Accumulate;
  logic [9:0]  SW;
  logic [16:0] Sum;
  logic        Busy;
  logic        Done;
  logic        Overflow;
  logic [1:0]  state_dbg;

  logic [17:0] exp_q[$];
  logic [16:0] model_sum;
  logic        model_ovf;
  int          n_checks;
  int          n_pass;

  accumulate_sequencer dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Clear          (Clear),
    .Run_Accumulate (Run_Accumulate),
    .SW             (SW),
    .Sum            (Sum),
    .Busy           (Busy),
    .Done           (Done),
    .Overflow       (Overflow),
    .state_dbg      (state_dbg)
  );

  // Clock / watchdog
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
  endtask

  task automatic model_add(input logic [9:0] sw);
    logic [17:0] t;
    t = {1'b0, model_sum} + 18'(sw);
    model_ovf = model_ovf | t[17];
    model_sum = t[16:0];
    exp_q.push_back({model_ovf, model_sum});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("done_seen", exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic press(input logic [9:0] sw, input int hold);
    SW = sw;
    Run_Accumulate = 1'b1;
    model_add(sw);
    repeat (hold) tick();
    Run_Accumulate = 1'b0;
    tick();
    tick();
    wait_drain();
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    model_sum = '0;
    model_ovf = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    if (Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("done_sum", 32'(Sum), 32'(e[16:0]));
        check("done_ovf", 32'(Overflow), 32'(e[17]));
      end
    end
  end

  // Directed sequence
  initial begin
    int busy_cnt, done_cnt, done_at, moved, bad;
    n_checks = 0;
    n_pass = 0;
    model_sum = '0;
    model_ovf = 1'b0;
    Reset = 1'b1;
    Clear = 1'b0;
    Run_Accumulate = 1'b0;
    SW = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check("reset_sum", 32'(Sum), 32'h0);
    check("reset_ovf", 32'(Overflow), 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);
    check("reset_done", 32'(Done), 32'h0);
    check("reset_state", 32'(state_dbg), 32'h0);
    bad = 0;
    repeat (20) begin
      tick();
      if (Sum !== 17'h0 || Busy !== 1'b0 || Done !== 1'b0 || Overflow !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'h0);

    // Held press: exact Busy/Done timing and a single add
    SW = 10'h3FF;
    Run_Accumulate = 1'b1;
    model_add(10'h3FF);
    busy_cnt = 0; done_cnt = 0; done_at = -1; moved = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (Busy) busy_cnt++;
      if (Busy && Sum !== 17'h0) moved++;
      if (Done) begin
        done_cnt++;
        done_at = c;
      end
    end
    Run_Accumulate = 1'b0;
    tick();
    tick();
    wait_drain();
    check("busy_cycles", 32'(busy_cnt), 32'd6);
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_latency", 32'(done_at), 32'd6);
    check("sum_held_in_add", 32'(moved), 32'd0);
    check("sum_3ff", 32'(Sum), 32'h003FF);
    press(10'h3FF, 30);
    check("sum_7fe", 32'(Sum), 32'h007FE);

    // Carry across a slice boundary, SW change mid-add ignored
    do_clear();
    check("clear_sum", 32'(Sum), 32'h0);
    repeat (15) press(10'h001, 8);
    check("sum_00f", 32'(Sum), 32'h0000F);
    SW = 10'h001;
    Run_Accumulate = 1'b1;
    model_add(10'h001);
    tick();
    tick();
    tick();
    SW = 10'h3FF;
    repeat (7) tick();
    Run_Accumulate = 1'b0;
    tick();
    tick();
    wait_drain();
    check("sum_010", 32'(Sum), 32'h00010);

    // Wrap-around and sticky overflow
    do_clear();
    repeat (129) press(10'h3FF, 8);
    check("wrap_sum", 32'(Sum), 32'h0037F);
    check("wrap_ovf", 32'(Overflow), 32'h1);
    press(10'h3FF, 8);
    check("sticky_sum", 32'(Sum), 32'h0077E);
    check("sticky_ovf", 32'(Overflow), 32'h1);
    do_clear();
    check("clear2_sum", 32'(Sum), 32'h0);
    check("clear2_ovf", 32'(Overflow), 32'h0);

    // Clear at E3 aborts, held button does not restart
    press(10'h100, 8);
    check("sum_100", 32'(Sum), 32'h00100);
    SW = 10'h003;
    Run_Accumulate = 1'b1;
    tick();
    tick();
    tick();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    model_sum = '0;
    model_ovf = 1'b0;
    check("abort_sum", 32'(Sum), 32'h0);
    check("abort_busy", 32'(Busy), 32'h0);
    check("abort_state", 32'(state_dbg), 32'h0);
    bad = 0;
    repeat (10) begin
      tick();
      if (Busy !== 1'b0 || Sum !== 17'h0) bad++;
    end
    check("abort_no_restart", 32'(bad), 32'h0);
    Run_Accumulate = 1'b0;
    tick();
    tick();
    press(10'h002, 8);
    check("sum_after_abort", 32'(Sum), 32'h00002);

    // Reset at E2 of an add
    SW = 10'h007;
    Run_Accumulate = 1'b1;
    tick();
    tick();
    Reset = 1'b1;
    Run_Accumulate = 1'b0;
    tick();
    check("rst_mid_sum", 32'(Sum), 32'h0);
    check("rst_mid_busy", 32'(Busy), 32'h0);
    check("rst_mid_done", 32'(Done), 32'h0);
    Reset = 1'b0;
    model_sum = '0;
    model_ovf = 1'b0;
    repeat (10) tick();
    press(10'h005, 8);
    check("sum_005", 32'(Sum), 32'h00005);

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accumulate_sequencer.md
Name: accumulate_sequencer

Overview:
- Control unit plus nibble-serial datapath for the lab 17-bit switch accumulator.
- Each press of Run_Accumulate adds the zero-extended 10-bit switch value into a 17-bit running sum. The add is sequenced one 4-bit slice per clock, with a registered carry between slices.
- Sits between the debounced board buttons/switches and the hex/LED display logic. Provides Busy/Done status for display gating.

Parameters:
- WIDTH, 17, accumulator width in bits.
- IN_WIDTH, 10, switch operand width; zero-extended to WIDTH.
- SLICE, 4, bits added per cycle.
- NSLICE, ceil(WIDTH/SLICE) = 5, derived (localparam). The last slice is WIDTH-SLICE*(NSLICE-1) = 1 bit wide.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Clear  in  1  synchronous, active-high clear of sum and overflow.
- Run_Accumulate  in  1  level input; each rising edge requests one accumulate.
- SW  in  IN_WIDTH  operand; sampled once per accumulate.
- Sum  out  WIDTH  architectural accumulator value.
- Busy  out  1  high in ADD and WB states.
- Done  out  1  one-cycle pulse when Sum is updated.
- Overflow  out  1  sticky carry-out of bit WIDTH-1.

Behaviour:
- Reset (sync, highest priority):
  - state=IDLE; Sum=0, Overflow=0, Done=0, Busy=0.
  - work register=0, carry=0, slice index=0, run_q=0.
- run_q is a register of Run_Accumulate. A start is detected when Run_Accumulate=1 and run_q=0.
- FSM states are IDLE, ADD, WB and HOLD.
- IDLE:
  - Start with Clear=0: latch operand = zero-extended SW, work=Sum, carry=0, idx=0, go to ADD.
  - Clear=1 in IDLE: Sum=0 and Overflow=0 at the next edge. Clear wins over a simultaneous start, and no add occurs.
- ADD, one edge per slice:
  - work[idx slice] = work slice + operand slice + carry; carry = slice carry-out; idx++.
  - At the edge processing idx=NSLICE-1, go to WB.
- WB:
  - Sum=work; Overflow |= final carry; Done=1 for exactly this one cycle; go to HOLD.
- HOLD:
  - Stay until Run_Accumulate=0, then IDLE.
  - Holding the button yields exactly one accumulate.
- Latency:
  - Start sampled at edge E0 (state becomes ADD).
  - Slices are processed at E1..E5; WB is entered at E5.
  - Sum and Done are updated at E6, so the new Sum is visible NSLICE+1 cycles after E0.
  - Done is high from E6 to E7. Busy is high from E0 to E6.
- Sum holds its old value throughout ADD. Intermediate work values never appear on Sum.
- Arithmetic is modulo 2^WIDTH; wrap-around is legal and flagged only by Overflow.
- Run_Accumulate falling during ADD/WB does not abort the add. HOLD then exits to IDLE at the next edge.
- Run_Accumulate rising while Busy cannot be a new start, because the fall must be observed in HOLD first.
- Clear during ADD or WB:
  - Abort; Sum=0, Overflow=0; state=IDLE at the next edge; no Done pulse.
  - If Run_Accumulate is still high, no restart occurs until it is released and pressed again.
- Clear in HOLD: Sum=0, Overflow=0; state stays HOLD until Run_Accumulate releases.
- SW changes after E0 have no effect on the add in progress.
- Reset mid-operation: immediate return to reset values at the next edge; no Done pulse.

Test Plan:
- Reset=1 for 3 cycles, then 0 -> Sum=0x00000, Overflow=0, Busy=0, Done=0; Run_Accumulate low keeps all unchanged for 20 cycles.
- SW=0x3FF, one Run_Accumulate press held 30 cycles -> Busy for 6 cycles, then a single Done pulse 6 cycles after the start edge, Sum=0x003FF. A second press gives Sum=0x007FE, confirming held press = one add.
- SW=0x001 with Sum=0x0000F (15 presses) -> next press gives Sum=0x00010, checking carry propagation across the slice boundary. SW is changed to 0x3FF at E2 with no effect on this result.
- 129 presses of SW=0x3FF from 0 -> Sum=0x0037F (131967 mod 131072), Overflow=1. Overflow stays 1 on further presses; Clear gives Sum=0, Overflow=0.
- Clear asserted one cycle at E3 of an add with Sum=0x00100 -> Sum=0, no Done, state IDLE. Run_Accumulate still high causes no new add until released and re-pressed.
- Reset asserted at E2 of an add -> next edge Sum=0, Busy=0, Done never pulses. A subsequent press of SW=0x005 gives Sum=0x00005.
